st7735_spi_tx: RTL and testbench

- Byte-level SPI serializer that sits directly downstream of the ST7735 command/pixel sequencer and drives the panel's CS, MOSI, DC and LCD_CLK pins.
- The sequencer hands over one byte plus its data/command flag via a valid/ready handshake.
- This block shifts the byte out in SPI mode 0, MSB first.
- CS stays asserted across back-to-back bytes and is released after a programmable idle hold.

---
 rtl/st7735_spi_tx_if.sv | 12 +
 rtl/st7735_spi_tx.sv | 119 +++++++++++
 tb/tb_st7735_spi_tx.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/st7735_spi_tx_if.sv
// Byte handshake between the ST7735 command/pixel sequencer and the SPI serializer.
// The sequencer (master) offers DATA_IN/DC_IN with VALID; the serializer (slave)
// takes the byte on any edge where VALID and READY are both high.
interface st7735_spi_tx_if;
  logic [7:0] DATA_IN;
  logic       DC_IN;
  logic       VALID;
  logic       READY;

  modport master (output DATA_IN, output DC_IN, output VALID, input READY);
  modport slave  (input DATA_IN, input DC_IN, input VALID, output READY);
endinterface

// File: rtl/st7735_spi_tx.sv
// SPI mode-0, MSB-first byte serializer for the ST7735 panel.
// It drives CS, MOSI, DC and LCD_CLK. CS stays low across back-to-back bytes.
// After the last byte, CS is released only once CS_HOLD idle cycles have passed.
module st7735_spi_tx #(
  parameter int CLK_DIV = 2,  // SYSTEM_CLK cycles per LCD_CLK half-period, 1..255
  parameter int CS_HOLD = 2   // SYSTEM_CLK cycles CS stays low after the last byte, 1..255
) (
  input  logic               SYSTEM_CLK,
  input  logic               SYSTEM_RST,
  st7735_spi_tx_if.slave     bus,
  output logic               BUSY,
  output logic               CS,
  output logic               MOSI,
  output logic               DC,
  output logic               LCD_CLK
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD - 1);

  state_t     state;
  logic [7:0] shreg;     // byte being sent; MOSI is picked out of it by bit_cnt
  logic [2:0] bit_cnt;   // bit currently on MOSI, 7 down to 0
  logic [7:0] div_cnt;   // cycles spent in the current LCD_CLK half-period
  logic [7:0] hold_cnt;  // cycles spent in HOLD without a new byte
  logic       ready_q;
  logic       accept;

  assign bus.READY = ready_q;
  assign accept    = bus.VALID && ready_q;

  // Single registered FSM: handshake, bit timing, CS hold-off and every pin output.
  // NOTE: all state here is written with <= so every register samples the pre-edge
  // values; mixing in blocking assignments would make results depend on statement order.
  always_ff @(posedge SYSTEM_CLK) begin
    if (SYSTEM_RST) begin
      // NOTE: the datapath registers (shift register, counters) are cleared along with
      // the control state; there is no RAM here, so a full clear is cheap and makes a
      // mid-byte reset leave nothing behind.
      state    <= IDLE;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      div_cnt  <= 8'd0;
      hold_cnt <= 8'd0;
      ready_q  <= 1'b1;
      BUSY     <= 1'b0;
      CS       <= 1'b1;
      MOSI     <= 1'b0;
      DC       <= 1'b0;
      LCD_CLK  <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            // A new byte starts the same way from IDLE or HOLD, so CS never glitches
            // high between back-to-back bytes. DC changes together with the first bit.
            state    <= SHIFT;
            shreg    <= bus.DATA_IN;
            bit_cnt  <= 3'd7;
            div_cnt  <= 8'd0;
            hold_cnt <= 8'd0;
            ready_q  <= 1'b0;
            BUSY     <= 1'b1;
            CS       <= 1'b0;
            DC       <= bus.DC_IN;
            MOSI     <= bus.DATA_IN[7];
            LCD_CLK  <= 1'b0;
          end else if (state == HOLD) begin
            // The accept branch above has priority, so a byte arriving on the
            // expiry edge keeps CS low.
            if (hold_cnt == HOLD_LAST) begin
              state    <= IDLE;
              CS       <= 1'b1;
              BUSY     <= 1'b0;
              hold_cnt <= 8'd0;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
        end

        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= 8'd0;
            if (!LCD_CLK) begin
              // Rising edge sits mid-bit; the panel samples MOSI here.
              LCD_CLK <= 1'b1;
            end else begin
              LCD_CLK <= 1'b0;
              if (bit_cnt == 3'd0) begin
                state    <= HOLD;
                MOSI     <= 1'b0;
                ready_q  <= 1'b1;
                hold_cnt <= 8'd0;
              end else begin
                // The next lower bit goes out on the same edge that LCD_CLK falls.
                bit_cnt <= bit_cnt - 3'd1;
                MOSI    <= shreg[bit_cnt - 3'd1];
              end
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_st7735_spi_tx.sv
// Directed bench for st7735_spi_tx.
// Instance A uses the default timing (CLK_DIV=2, CS_HOLD=2); instance B uses the
// fastest timing (CLK_DIV=1, CS_HOLD=1). Cycle index k below means "observed just
// after the edge that follows accept edge T by k-1 edges". So k=1 is the first cycle
// with state SHIFT.
module tb_st7735_spi_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  st7735_spi_tx_if bus_a ();
  st7735_spi_tx_if bus_b ();

  logic a_busy, a_cs, a_mosi, a_dc, a_lcd_clk;
  logic b_busy, b_cs, b_mosi, b_dc, b_lcd_clk;

  st7735_spi_tx #(.CLK_DIV(2), .CS_HOLD(2)) dut_a (
    .SYSTEM_CLK (clk),
    .SYSTEM_RST (rst),
    .bus        (bus_a),
    .BUSY       (a_busy),
    .CS         (a_cs),
    .MOSI       (a_mosi),
    .DC         (a_dc),
    .LCD_CLK    (a_lcd_clk)
  );

  st7735_spi_tx #(.CLK_DIV(1), .CS_HOLD(1)) dut_b (
    .SYSTEM_CLK (clk),
    .SYSTEM_RST (rst),
    .bus        (bus_b),
    .BUSY       (b_busy),
    .CS         (b_cs),
    .MOSI       (b_mosi),
    .DC         (b_dc),
    .LCD_CLK    (b_lcd_clk)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one byte on instance A from an idle/ready state and records what it sees:
  // the bits sampled on LCD_CLK rising edges, the cycles of the first and last rising
  // edge, the cycles where READY and CS return high, and the pin values at k=1.
  task automatic run_byte_a(input logic [7:0] data, input logic dc,
                            output logic [7:0] bits, output int rises,
                            output int first_rise, output int last_rise,
                            output int ready_k, output int cs_k,
                            output logic k1_cs, output logic k1_mosi, output logic k1_ready);
    logic prev;
    bus_a.DATA_IN = data;
    bus_a.DC_IN   = dc;
    bus_a.VALID   = 1'b1;
    tick();
    bus_a.VALID = 1'b0;
    k1_cs    = a_cs;
    k1_mosi  = a_mosi;
    k1_ready = bus_a.READY;
    prev = a_lcd_clk;
    bits = 8'h00; rises = 0; first_rise = -1; last_rise = -1; ready_k = -1; cs_k = -1;
    for (int k = 2; k <= 45; k++) begin
      tick();
      if (!prev && a_lcd_clk) begin
        rises++;
        bits = {bits[6:0], a_mosi};
        if (first_rise < 0) first_rise = k;
        last_rise = k;
      end
      prev = a_lcd_clk;
      if (ready_k < 0 && bus_a.READY) ready_k = k;
      if (cs_k < 0 && a_cs) cs_k = k;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({a_cs, a_lcd_clk, a_mosi, a_dc, bus_a.READY, a_busy} !== 6'b100010)
      $display("FAIL reset_a_first_edge: got %b expected 100010",
               {a_cs, a_lcd_clk, a_mosi, a_dc, bus_a.READY, a_busy});
    else pass_cnt++;
    total_cnt++;
    if ({b_cs, b_lcd_clk, b_mosi, b_dc, bus_b.READY, b_busy} !== 6'b100010)
      $display("FAIL reset_b_first_edge: got %b expected 100010",
               {b_cs, b_lcd_clk, b_mosi, b_dc, bus_b.READY, b_busy});
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total_cnt++;
      if ({a_cs, a_lcd_clk, a_mosi, a_dc, bus_a.READY, a_busy} !== 6'b100010)
        $display("FAIL idle_a cycle %0d: got %b expected 100010", i,
                 {a_cs, a_lcd_clk, a_mosi, a_dc, bus_a.READY, a_busy});
      else pass_cnt++;
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] bits;
    int rises, first_rise, last_rise, ready_k, cs_k;
    logic k1_cs, k1_mosi, k1_ready;
    run_byte_a(8'hA5, 1'b0, bits, rises, first_rise, last_rise, ready_k, cs_k,
               k1_cs, k1_mosi, k1_ready);
    total_cnt++;
    if (k1_cs !== 1'b0) $display("FAIL a5_cs_low_at_t1: got %b expected 0", k1_cs);
    else pass_cnt++;
    total_cnt++;
    if (k1_mosi !== 1'b1) $display("FAIL a5_mosi_bit7_at_t1: got %b expected 1", k1_mosi);
    else pass_cnt++;
    total_cnt++;
    if (k1_ready !== 1'b0) $display("FAIL a5_ready_low_at_t1: got %b expected 0", k1_ready);
    else pass_cnt++;
    total_cnt++;
    if (rises !== 8) $display("FAIL a5_rise_count: got %0d expected 8", rises);
    else pass_cnt++;
    total_cnt++;
    if (first_rise !== 3) $display("FAIL a5_first_rise: got T+%0d expected T+3", first_rise);
    else pass_cnt++;
    total_cnt++;
    if (last_rise !== 31) $display("FAIL a5_last_rise: got T+%0d expected T+31", last_rise);
    else pass_cnt++;
    total_cnt++;
    if (bits !== 8'hA5) $display("FAIL a5_bits: got %h expected a5", bits);
    else pass_cnt++;
    total_cnt++;
    if (ready_k !== 33) $display("FAIL a5_ready_return: got T+%0d expected T+33", ready_k);
    else pass_cnt++;
    total_cnt++;
    if (cs_k !== 35) $display("FAIL a5_cs_release: got T+%0d expected T+35", cs_k);
    else pass_cnt++;
    total_cnt++;
    if ({a_busy, a_mosi, a_dc, a_lcd_clk} !== 4'b0000)
      $display("FAIL a5_idle_after: got %b expected 0000", {a_busy, a_mosi, a_dc, a_lcd_clk});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [23:0] bits = 24'h0;
    logic        prev;
    logic        rdy_before;
    int          rises = 0, accepts = 1, cs_highs = 0, cs_k = -1, nrr = 0;
    int          rr[3] = '{-1, -1, -1};
    logic        prev_ready;
    bus_a.DATA_IN = 8'h2C;
    bus_a.DC_IN   = 1'b0;
    bus_a.VALID   = 1'b1;
    tick();
    bus_a.DATA_IN = 8'hFF;
    bus_a.DC_IN   = 1'b1;
    prev = a_lcd_clk;
    prev_ready = bus_a.READY;
    for (int k = 2; k <= 105; k++) begin
      rdy_before = bus_a.READY;
      tick();
      if (rdy_before && bus_a.VALID) begin
        accepts++;
        if (accepts == 3) bus_a.VALID = 1'b0;
      end
      if (!prev && a_lcd_clk) begin
        rises++;
        bits = {bits[22:0], a_mosi};
      end
      prev = a_lcd_clk;
      if (!prev_ready && bus_a.READY && nrr < 3) begin
        rr[nrr] = k;
        nrr++;
      end
      prev_ready = bus_a.READY;
      if (k <= 100 && a_cs) cs_highs++;
      if (cs_k < 0 && a_cs) cs_k = k;
      if (k == 33) begin
        total_cnt++;
        if (a_dc !== 1'b0) $display("FAIL b2b_dc_before_byte2: got %b expected 0", a_dc);
        else pass_cnt++;
      end
      if (k == 34) begin
        total_cnt++;
        if ({a_dc, a_mosi} !== 2'b11)
          $display("FAIL b2b_dc_with_first_bit: got dc,mosi=%b expected 11", {a_dc, a_mosi});
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (cs_highs !== 0) $display("FAIL b2b_cs_glitch: got %0d high cycles expected 0", cs_highs);
    else pass_cnt++;
    total_cnt++;
    if (rises !== 24) $display("FAIL b2b_rise_count: got %0d expected 24", rises);
    else pass_cnt++;
    total_cnt++;
    if (bits !== 24'h2CFFFF) $display("FAIL b2b_bits: got %h expected 2cffff", bits);
    else pass_cnt++;
    total_cnt++;
    if (rr[0] !== 33 || rr[1] !== 66 || rr[2] !== 99)
      $display("FAIL b2b_ready_returns: got T+%0d,T+%0d,T+%0d expected T+33,T+66,T+99",
               rr[0], rr[1], rr[2]);
    else pass_cnt++;
    total_cnt++;
    if (cs_k !== 101) $display("FAIL b2b_cs_release: got T+%0d expected T+101", cs_k);
    else pass_cnt++;
  endtask

  task automatic test_hold_expiry_accept();
    logic [7:0] bits = 8'h00;
    logic       prev;
    int         rises = 0, cs_k = -1;
    bus_a.DATA_IN = 8'h55;
    bus_a.DC_IN   = 1'b1;
    bus_a.VALID   = 1'b1;
    tick();
    bus_a.VALID = 1'b0;
    for (int k = 2; k <= 34; k++) begin
      tick();
      if (cs_k < 0 && a_cs) cs_k = k;
    end
    // One cycle before the hold would expire on its own: still HOLD with CS low.
    total_cnt++;
    if ({bus_a.READY, a_cs} !== 2'b10)
      $display("FAIL hold_state_before_expiry: got ready,cs=%b expected 10", {bus_a.READY, a_cs});
    else pass_cnt++;
    bus_a.DATA_IN = 8'hC3;
    bus_a.DC_IN   = 1'b0;
    bus_a.VALID   = 1'b1;
    tick();  // k=35: the expiry edge, which also accepts
    bus_a.VALID = 1'b0;
    total_cnt++;
    if ({a_cs, a_mosi, a_dc, bus_a.READY, a_busy} !== 5'b01001)
      $display("FAIL hold_expiry_accept: got cs,mosi,dc,ready,busy=%b expected 01001",
               {a_cs, a_mosi, a_dc, bus_a.READY, a_busy});
    else pass_cnt++;
    if (cs_k < 0 && a_cs) cs_k = 35;
    prev = a_lcd_clk;
    for (int k = 36; k <= 75; k++) begin
      tick();
      if (!prev && a_lcd_clk) begin
        rises++;
        bits = {bits[6:0], a_mosi};
      end
      prev = a_lcd_clk;
      if (cs_k < 0 && a_cs) cs_k = k;
    end
    total_cnt++;
    if (cs_k !== 69) $display("FAIL hold_expiry_cs_release: got T+%0d expected T+69", cs_k);
    else pass_cnt++;
    total_cnt++;
    if (rises !== 8 || bits !== 8'hC3)
      $display("FAIL hold_expiry_byte2: got %0d rises bits %h expected 8 rises bits c3", rises, bits);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] bits;
    int rises, first_rise, last_rise, ready_k, cs_k;
    logic k1_cs, k1_mosi, k1_ready;
    bus_a.DATA_IN = 8'h81;
    bus_a.DC_IN   = 1'b1;
    bus_a.VALID   = 1'b1;
    tick();
    bus_a.VALID = 1'b0;
    for (int k = 2; k <= 18; k++) tick();
    // k=18 is the low half of bit 3 (bits occupy k=1+4i..4+4i, i=4 is bit 3).
    total_cnt++;
    if ({a_cs, a_lcd_clk, a_mosi, a_dc} !== 4'b0001)
      $display("FAIL rst_mid_bit3_state: got cs,clk,mosi,dc=%b expected 0001",
               {a_cs, a_lcd_clk, a_mosi, a_dc});
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({a_cs, a_lcd_clk, a_mosi, a_dc, bus_a.READY, a_busy} !== 6'b100010)
      $display("FAIL rst_mid_byte_outputs: got %b expected 100010",
               {a_cs, a_lcd_clk, a_mosi, a_dc, bus_a.READY, a_busy});
    else pass_cnt++;
    run_byte_a(8'h3A, 1'b1, bits, rises, first_rise, last_rise, ready_k, cs_k,
               k1_cs, k1_mosi, k1_ready);
    total_cnt++;
    if (bits !== 8'h3A || rises !== 8)
      $display("FAIL rst_then_3a_bits: got %0d rises bits %h expected 8 rises bits 3a", rises, bits);
    else pass_cnt++;
    total_cnt++;
    if (k1_cs !== 1'b0 || k1_mosi !== 1'b0 || cs_k !== 35)
      $display("FAIL rst_then_3a_framing: got cs=%b mosi=%b cs_release=T+%0d expected 0,0,T+35",
               k1_cs, k1_mosi, cs_k);
    else pass_cnt++;
    total_cnt++;
    if (a_dc !== 1'b1) $display("FAIL rst_then_3a_dc_held: got %b expected 1", a_dc);
    else pass_cnt++;
  endtask

  task automatic test_fast_timing();
    logic prev;
    int   toggles = 0, rises = 0, mosi_ones = 0, cs_k = -1;
    logic ready17 = 1'b0;
    bus_b.DATA_IN = 8'h00;
    bus_b.DC_IN   = 1'b0;
    bus_b.VALID   = 1'b1;
    tick();
    bus_b.VALID = 1'b0;
    total_cnt++;
    if ({b_cs, b_lcd_clk} !== 2'b00)
      $display("FAIL fast_start: got cs,clk=%b expected 00", {b_cs, b_lcd_clk});
    else pass_cnt++;
    prev = b_lcd_clk;
    if (b_mosi) mosi_ones++;
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (k <= 17 && b_lcd_clk != prev) toggles++;
      if (!prev && b_lcd_clk) rises++;
      prev = b_lcd_clk;
      if (b_mosi) mosi_ones++;
      if (k == 17) ready17 = bus_b.READY;
      if (cs_k < 0 && b_cs) cs_k = k;
    end
    total_cnt++;
    if (toggles !== 16) $display("FAIL fast_toggles: got %0d expected 16", toggles);
    else pass_cnt++;
    total_cnt++;
    if (rises !== 8) $display("FAIL fast_rise_count: got %0d expected 8", rises);
    else pass_cnt++;
    total_cnt++;
    if (mosi_ones !== 0) $display("FAIL fast_mosi_zero: got %0d high cycles expected 0", mosi_ones);
    else pass_cnt++;
    total_cnt++;
    if (ready17 !== 1'b1) $display("FAIL fast_ready_return: got %b at T+17 expected 1", ready17);
    else pass_cnt++;
    total_cnt++;
    if (cs_k !== 18) $display("FAIL fast_cs_release: got T+%0d expected T+18", cs_k);
    else pass_cnt++;
  endtask

  initial begin
    bus_a.DATA_IN = 8'h00; bus_a.DC_IN = 1'b0; bus_a.VALID = 1'b0;
    bus_b.DATA_IN = 8'h00; bus_b.DC_IN = 1'b0; bus_b.VALID = 1'b0;
    tick();
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_hold_expiry_accept();
    test_reset_mid_byte();
    test_fast_timing();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
